// File: rtl/lcd_hd44780_ctrl_if.sv
// Upstream command handshake for the HD44780 controller: one byte per valid/ready transfer.
interface lcd_hd44780_ctrl_if;
  logic       cmd_valid_in;
  logic       cmd_rs_in;
  logic [7:0] cmd_data_in;
  logic       cmd_ready_out;

  modport master (output cmd_valid_in, cmd_rs_in, cmd_data_in, input cmd_ready_out);
  modport slave  (input cmd_valid_in, cmd_rs_in, cmd_data_in, output cmd_ready_out);
endinterface

// File: rtl/lcd_hd44780_ctrl.sv
// HD44780 character-LCD write controller: timed power-up/init sequence, then
// upstream bytes strobed out in 8-bit or 4-bit bus mode with counter-based execution waits.
module lcd_hd44780_ctrl #(
  parameter int CLK_HZ     = 20000000,
  parameter int BUS_4BIT   = 0,
  parameter int ROWS       = 2,
  parameter int POWERUP_US = 40000,
  parameter int EXEC_US    = 40,
  parameter int CLEAR_US   = 1640
) (
  input  logic               lcd_clk_in,
  input  logic               lcd_rst_n_in,
  lcd_hd44780_ctrl_if.slave  cmd,
  output logic               init_done_out,
  output logic               LCD_RS,
  output logic               LCD_RW,
  output logic               LCD_EN,
  output logic [7:0]         LCD_DATA
);

  localparam int US_DIV  = CLK_HZ / 1000000;
  localparam int PW      = (US_DIV > 1) ? $clog2(US_DIV) : 1;
  localparam int WMAX_A  = (POWERUP_US > 4100) ? POWERUP_US : 4100;
  localparam int WMAX_B  = (CLEAR_US > EXEC_US) ? CLEAR_US : EXEC_US;
  localparam int WMAX    = (WMAX_A > WMAX_B) ? WMAX_A : WMAX_B;
  localparam int WW      = $clog2(WMAX + 1);
  localparam int NINIT   = (BUS_4BIT != 0) ? 9 : 8;
  localparam int CLR_IDX = (BUS_4BIT != 0) ? 6 : 5;
  localparam logic [7:0] FS = {3'b001, (BUS_4BIT == 0), (ROWS > 1), 3'b000};

  typedef enum logic [2:0] {S_PWRUP, S_INIT, S_IDLE, S_SETUP, S_EN_HI, S_HOLD, S_WAIT} state_t;

  state_t        r_state;
  logic [PW-1:0] r_us_cnt;
  logic [WW-1:0] r_wait, r_exec;
  logic [3:0]    r_idx;
  logic [7:0]    r_byte, r_data;
  logic          r_single, r_lo, r_ready, r_done, r_en, r_lcd_rs;

  logic          w_tick, w_ini_single, w_ini_last, w_cmd_clr;
  logic [7:0]    w_ini_byte;
  logic [WW-1:0] w_ini_wait;

  // Free-running microsecond prescaler; every timed state advances only on w_tick.
  assign w_tick = (r_us_cnt == PW'(US_DIV - 1));

  always_ff @(posedge lcd_clk_in or negedge lcd_rst_n_in) begin
    if (!lcd_rst_n_in)  r_us_cnt <= '0;
    else if (w_tick)    r_us_cnt <= '0;
    else                r_us_cnt <= r_us_cnt + 1'b1;
  end

  // Init table; the 4-bit sequence has four single-nibble wake-up writes ahead of the common tail.
  always_comb begin
    w_ini_byte   = 8'h0C;
    w_ini_single = 1'b0;
    if (BUS_4BIT != 0) begin
      case (r_idx)
        4'd0, 4'd1, 4'd2: begin w_ini_byte = 8'h30; w_ini_single = 1'b1; end
        4'd3:             begin w_ini_byte = 8'h20; w_ini_single = 1'b1; end
        4'd4:             w_ini_byte = FS;
        4'd5:             w_ini_byte = 8'h08;
        4'd6:             w_ini_byte = 8'h01;
        4'd7:             w_ini_byte = 8'h06;
        default:          w_ini_byte = 8'h0C;
      endcase
    end else begin
      case (r_idx)
        4'd0, 4'd1, 4'd2: w_ini_byte = 8'h30;
        4'd3:             w_ini_byte = FS;
        4'd4:             w_ini_byte = 8'h08;
        4'd5:             w_ini_byte = 8'h01;
        4'd6:             w_ini_byte = 8'h06;
        default:          w_ini_byte = 8'h0C;
      endcase
    end
  end

  always_comb begin
    w_ini_wait = WW'(EXEC_US);
    if (r_idx == 4'd0)                w_ini_wait = WW'(4100);
    else if (r_idx == 4'd1)           w_ini_wait = WW'(100);
    else if (r_idx == 4'(CLR_IDX))    w_ini_wait = WW'(CLEAR_US);
  end

  assign w_ini_last = (r_idx == 4'(NINIT - 1));
  assign w_cmd_clr  = !cmd.cmd_rs_in && (cmd.cmd_data_in[7:2] == 6'd0) && (cmd.cmd_data_in != 8'd0);

  function automatic logic [7:0] f_bus(input logic [7:0] b, input logic lo);
    if (BUS_4BIT != 0) return {(lo ? b[3:0] : b[7:4]), 4'h0};
    return b;
  endfunction

  always_ff @(posedge lcd_clk_in or negedge lcd_rst_n_in) begin
    if (!lcd_rst_n_in) begin
      r_state  <= S_PWRUP;
      r_wait   <= WW'(POWERUP_US);
      r_exec   <= '0;
      r_idx    <= '0;
      r_byte   <= '0;
      r_data   <= '0;
      r_single <= 1'b0;
      r_lo     <= 1'b0;
      r_ready  <= 1'b0;
      r_done   <= 1'b0;
      r_en     <= 1'b0;
      r_lcd_rs <= 1'b0;
    end else begin
      case (r_state)
        S_PWRUP: if (w_tick) begin
          if (r_wait <= WW'(1)) r_state <= S_INIT;
          else                  r_wait  <= r_wait - 1'b1;
        end
        S_INIT: begin
          r_byte   <= w_ini_byte;
          r_single <= w_ini_single;
          r_lo     <= 1'b0;
          r_exec   <= w_ini_wait;
          r_lcd_rs <= 1'b0;
          r_data   <= f_bus(w_ini_byte, 1'b0);
          r_state  <= S_SETUP;
        end
        S_IDLE: if (cmd.cmd_valid_in && r_ready) begin
          r_ready  <= 1'b0;
          r_byte   <= cmd.cmd_data_in;
          r_single <= 1'b0;
          r_lo     <= 1'b0;
          r_exec   <= w_cmd_clr ? WW'(CLEAR_US) : WW'(EXEC_US);
          r_lcd_rs <= cmd.cmd_rs_in;
          r_data   <= f_bus(cmd.cmd_data_in, 1'b0);
          r_state  <= S_SETUP;
        end
        S_SETUP: if (w_tick) begin
          r_en    <= 1'b1;
          r_state <= S_EN_HI;
        end
        S_EN_HI: if (w_tick) begin
          r_en    <= 1'b0;
          r_state <= S_HOLD;
        end
        S_HOLD: if (w_tick) begin
          // Full bytes on a 4-bit bus go straight into the low-nibble transfer.
          if ((BUS_4BIT != 0) && !r_single && !r_lo) begin
            r_lo    <= 1'b1;
            r_data  <= f_bus(r_byte, 1'b1);
            r_state <= S_SETUP;
          end else begin
            r_wait  <= r_exec;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: if (w_tick) begin
          if (r_wait <= WW'(1)) begin
            if (r_done) begin
              r_ready <= 1'b1;
              r_state <= S_IDLE;
            end else if (w_ini_last) begin
              r_done  <= 1'b1;
              r_ready <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_idx   <= r_idx + 4'd1;
              r_state <= S_INIT;
            end
          end else begin
            r_wait <= r_wait - 1'b1;
          end
        end
        default: r_state <= S_PWRUP;
      endcase
    end
  end

  assign cmd.cmd_ready_out = r_ready;
  assign init_done_out     = r_done;
  assign LCD_RS            = r_lcd_rs;
  assign LCD_RW            = 1'b0;
  assign LCD_EN            = r_en;
  assign LCD_DATA          = r_data;

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// Bench for lcd_hd44780_ctrl: an 8-bit/2-line and a 4-bit/1-line instance share clock and reset.
`timescale 1ns/1ps
module tb_lcd_hd44780_ctrl;
  localparam int CLK  = 2000000;
  localparam int UDIV = 2;
  localparam int PWR  = 50;
  localparam int EXEC = 40;
  localparam int CLR  = 1640;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         width;
    bit         pre_ok;
    bit         post_ok;
    int         t_rise;
  } strobe_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #250 clk = ~clk;

  lcd_hd44780_ctrl_if if8 ();
  lcd_hd44780_ctrl_if if4 ();

  logic [1:0]       done, lrs, lrw, len;
  logic [1:0][7:0]  dat;

  lcd_hd44780_ctrl #(.CLK_HZ(CLK), .BUS_4BIT(0), .ROWS(2), .POWERUP_US(PWR), .EXEC_US(EXEC), .CLEAR_US(CLR)) u_dut8 (
    .lcd_clk_in(clk), .lcd_rst_n_in(rst_n), .cmd(if8), .init_done_out(done[0]),
    .LCD_RS(lrs[0]), .LCD_RW(lrw[0]), .LCD_EN(len[0]), .LCD_DATA(dat[0]));

  lcd_hd44780_ctrl #(.CLK_HZ(CLK), .BUS_4BIT(1), .ROWS(1), .POWERUP_US(PWR), .EXEC_US(EXEC), .CLEAR_US(CLR)) u_dut4 (
    .lcd_clk_in(clk), .lcd_rst_n_in(rst_n), .cmd(if4), .init_done_out(done[1]),
    .LCD_RS(lrs[1]), .LCD_RW(lrw[1]), .LCD_EN(len[1]), .LCD_DATA(dat[1]));

  int nchk = 0;
  int nerr = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor: records every EN pulse with its bus value, width and data stability.
  strobe_t sq0[$];
  strobe_t sq1[$];
  strobe_t cur[2];
  logic    pen[2], prs[2], pdone[2];
  logic [7:0] pdat[2];
  int      acnt[2], t_done[2];
  bit      lo_nz = 0, rw_bad = 0;

  initial begin
    for (int i = 0; i < 2; i++) begin pen[i] = 0; prs[i] = 0; pdat[i] = 0; acnt[i] = 0; pdone[i] = 0; t_done[i] = 0; end
    forever begin
      @(negedge clk);
      if (dat[1][3:0] != 4'h0) lo_nz = 1;
      if (lrw != 2'b00) rw_bad = 1;
      for (int i = 0; i < 2; i++) begin
        if (!rst_n) begin
          pen[i] = 0; acnt[i] = 0; pdone[i] = 0;
        end else begin
          if (done[i] && !pdone[i]) t_done[i] = cyc;
          if (len[i] && !pen[i]) begin
            cur[i].rs = lrs[i]; cur[i].data = dat[i]; cur[i].width = 1; cur[i].t_rise = cyc;
            cur[i].pre_ok = (dat[i] == pdat[i]) && (lrs[i] == prs[i]);
            cur[i].post_ok = 1;
          end else if (len[i]) begin
            cur[i].width++;
            if (dat[i] != cur[i].data || lrs[i] != cur[i].rs) cur[i].post_ok = 0;
          end else if (pen[i]) begin
            if (dat[i] != cur[i].data || lrs[i] != cur[i].rs) cur[i].post_ok = 0;
            acnt[i] = 1;
          end else if (acnt[i] == 1) begin
            if (dat[i] != cur[i].data || lrs[i] != cur[i].rs) cur[i].post_ok = 0;
            if (i == 0) sq0.push_back(cur[i]); else sq1.push_back(cur[i]);
            acnt[i] = 0;
          end
          pen[i] = len[i]; prs[i] = lrs[i]; pdat[i] = dat[i]; pdone[i] = done[i];
        end
      end
    end
  end

  initial begin
    #30_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---- reference model helpers ----
  function automatic int exp_wait_us(input logic rs, input logic [7:0] d);
    return (!rs && d >= 8'd1 && d <= 8'd3) ? CLR : EXEC;
  endfunction

  function automatic logic [7:0] rnd_byte(input logic rs);
    logic [7:0] d;
    d = 8'($urandom);
    if (!rs && d < 8'd4) d = d | 8'h40;
    return d;
  endfunction

  task automatic drive(input int sel, input logic v, input logic rs, input logic [7:0] d);
    if (sel == 0) begin if8.cmd_valid_in = v; if8.cmd_rs_in = rs; if8.cmd_data_in = d; end
    else          begin if4.cmd_valid_in = v; if4.cmd_rs_in = rs; if4.cmd_data_in = d; end
  endtask

  function automatic logic rdy(input int sel);
    return (sel == 0) ? if8.cmd_ready_out : if4.cmd_ready_out;
  endfunction

  task automatic get_strobe(input int sel, output strobe_t s, output bit got);
    got = 0;
    s.rs = 0; s.data = 0; s.width = 0; s.pre_ok = 0; s.post_ok = 0; s.t_rise = 0;
    if (sel == 0 && sq0.size() > 0) begin s = sq0.pop_front(); got = 1; end
    if (sel == 1 && sq1.size() > 0) begin s = sq1.pop_front(); got = 1; end
  endtask

  // One handshake; returns the number of sampled cycles ready stayed low afterwards.
  task automatic send(input int sel, input logic rs, input logic [7:0] d, output int lowc, output bit ok);
    int n;
    ok = 1; lowc = 0; n = 0;
    @(negedge clk);
    drive(sel, 1'b1, rs, d);
    while (!rdy(sel) && n < 20000) begin @(negedge clk); n++; end
    if (!rdy(sel)) begin ok = 0; drive(sel, 1'b0, 1'b0, 8'h00); return; end
    @(negedge clk);
    drive(sel, 1'b0, 1'($urandom), 8'($urandom));
    while (!rdy(sel) && lowc < 20000) begin lowc++; @(negedge clk); end
    if (!rdy(sel)) ok = 0;
  endtask

  // ---- tests ----
  task automatic test_reset();
    rst_n = 0;
    drive(0, 0, 0, 0); drive(1, 0, 0, 0);
    repeat (5) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      nchk++;
      if ({lrs[i], lrw[i], len[i], dat[i], rdy(i), done[i]} !== 13'd0) begin
        $display("FAIL reset_state dut%0d got rs=%b rw=%b en=%b data=%h rdy=%b done=%b want all 0",
                 i, lrs[i], lrw[i], len[i], dat[i], rdy(i), done[i]);
        nerr++;
      end
    end
    sq0.delete(); sq1.delete();
  endtask

  task automatic test_init8();
    logic [7:0] seq[$];
    logic [7:0] fs;
    int n, t0;
    strobe_t s;
    @(negedge clk); rst_n = 1; t0 = cyc;
    n = 0;
    while (!done[0] && n < 20000) begin @(negedge clk); n++; end
    nchk++;
    if (!done[0]) begin $display("FAIL init8_done timeout after %0d cycles", n); nerr++; return; end
    fs = 8'h20 | 8'h10 | 8'h08;
    seq = '{8'h30, 8'h30, 8'h30, fs, 8'h08, 8'h01, 8'h06, 8'h0C};
    nchk++;
    if (sq0.size() != seq.size()) begin
      $display("FAIL init8_count got %0d strobes want %0d", sq0.size(), seq.size()); nerr++; return;
    end
    for (int k = 0; k < seq.size(); k++) begin
      s = sq0[k];
      nchk++;
      if (s.rs !== 1'b0 || s.data !== seq[k] || s.width != UDIV) begin
        $display("FAIL init8_strobe[%0d] got rs=%b data=%h width=%0d want rs=0 data=%h width=%0d",
                 k, s.rs, s.data, s.width, seq[k], UDIV);
        nerr++;
      end
    end
    nchk++;
    if (sq0[0].t_rise - t0 < UDIV * (PWR - 1)) begin
      $display("FAIL init8_powerup got %0d cycles want >= %0d", sq0[0].t_rise - t0, UDIV * (PWR - 1)); nerr++;
    end
    nchk++;
    if (sq0[1].t_rise - sq0[0].t_rise < UDIV * 4100) begin
      $display("FAIL init8_gap4100 got %0d cycles want >= %0d", sq0[1].t_rise - sq0[0].t_rise, UDIV * 4100); nerr++;
    end
    nchk++;
    if (sq0[2].t_rise - sq0[1].t_rise < UDIV * 100) begin
      $display("FAIL init8_gap100 got %0d cycles want >= %0d", sq0[2].t_rise - sq0[1].t_rise, UDIV * 100); nerr++;
    end
    nchk++;
    if (sq0[6].t_rise - sq0[5].t_rise < UDIV * CLR) begin
      $display("FAIL init8_gapclear got %0d cycles want >= %0d", sq0[6].t_rise - sq0[5].t_rise, UDIV * CLR); nerr++;
    end
    nchk++;
    if (t_done[0] - sq0[7].t_rise < UDIV * EXEC) begin
      $display("FAIL init8_done_time got %0d cycles after last strobe want >= %0d", t_done[0] - sq0[7].t_rise, UDIV * EXEC); nerr++;
    end
    sq0.delete();
  endtask

  task automatic test_init4();
    logic [3:0] seq[$];
    logic [7:0] body[5];
    int n;
    strobe_t s;
    n = 0;
    while (!done[1] && n < 20000) begin @(negedge clk); n++; end
    nchk++;
    if (!done[1]) begin $display("FAIL init4_done timeout after %0d cycles", n); nerr++; return; end
    body = '{8'h20, 8'h08, 8'h01, 8'h06, 8'h0C};
    seq = '{4'h3, 4'h3, 4'h3, 4'h2};
    for (int k = 0; k < 5; k++) begin seq.push_back(body[k][7:4]); seq.push_back(body[k][3:0]); end
    nchk++;
    if (sq1.size() != seq.size()) begin
      $display("FAIL init4_count got %0d strobes want %0d", sq1.size(), seq.size()); nerr++; return;
    end
    for (int k = 0; k < seq.size(); k++) begin
      s = sq1[k];
      nchk++;
      if (s.rs !== 1'b0 || s.data !== {seq[k], 4'h0} || s.width != UDIV) begin
        $display("FAIL init4_strobe[%0d] got rs=%b data=%h width=%0d want rs=0 data=%h width=%0d",
                 k, s.rs, s.data, s.width, {seq[k], 4'h0}, UDIV);
        nerr++;
      end
    end
    nchk++;
    if (lo_nz) begin $display("FAIL init4_low_nibble got nonzero DATA[3:0] want 0"); nerr++; end
    sq1.delete();
  endtask

  task automatic test_char41();
    int lowc, n;
    bit ok, got;
    strobe_t s;
    send(0, 1'b1, 8'h41, lowc, ok);
    n = 2 * EXEC;
    nchk++;
    if (!ok || lowc < n + 4 || lowc > n + 8) begin
      $display("FAIL char41_ready got ok=%0d low=%0d cycles want %0d..%0d", ok, lowc, n + 4, n + 8); nerr++;
    end
    nchk++;
    if (sq0.size() != 1) begin $display("FAIL char41_count got %0d strobes want 1", sq0.size()); nerr++; end
    get_strobe(0, s, got);
    nchk++;
    if (!got || s.rs !== 1'b1 || s.data !== 8'h41 || !s.pre_ok || !s.post_ok) begin
      $display("FAIL char41_strobe got rs=%b data=%h pre=%0d post=%0d want rs=1 data=41 stable", s.rs, s.data, s.pre_ok, s.post_ok);
      nerr++;
    end
    sq0.delete();
  endtask

  task automatic test_clear_home();
    logic [8:0] tbl[7];
    int lowc, w;
    bit ok, got;
    strobe_t s;
    tbl = '{{1'b0, 8'h01}, {1'b0, 8'h80}, {1'b0, 8'h00}, {1'b0, 8'h04}, {1'b1, 8'h01}, {1'b0, 8'h02}, {1'b1, 8'h03}};
    for (int k = 0; k < 7; k++) begin
      send(0, tbl[k][8], tbl[k][7:0], lowc, ok);
      w = 2 * exp_wait_us(tbl[k][8], tbl[k][7:0]);
      nchk++;
      if (!ok || lowc < w + 4 || lowc > w + 8) begin
        $display("FAIL exec_wait[%0d] rs=%b data=%h got low=%0d cycles want %0d..%0d", k, tbl[k][8], tbl[k][7:0], lowc, w + 4, w + 8);
        nerr++;
      end
      get_strobe(0, s, got);
      nchk++;
      if (!got || s.rs !== tbl[k][8] || s.data !== tbl[k][7:0] || sq0.size() != 0) begin
        $display("FAIL exec_strobe[%0d] got rs=%b data=%h extra=%0d want rs=%b data=%h", k, s.rs, s.data, sq0.size(), tbl[k][8], tbl[k][7:0]);
        nerr++;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] pres[3];
    logic [8:0] c;
    int th[3];
    int h, n;
    bit got;
    strobe_t s;
    h = 0; n = 0;
    @(negedge clk);
    c[8] = 1'($urandom); c[7:0] = rnd_byte(c[8]);
    drive(0, 1'b1, c[8], c[7:0]);
    while (h < 3 && n < 5000) begin
      if (rdy(0)) begin pres[h] = c; th[h] = cyc; h++; end
      @(negedge clk); n++;
      c[8] = 1'($urandom); c[7:0] = rnd_byte(c[8]);
      drive(0, (h < 3), c[8], c[7:0]);
    end
    n = 0;
    while (!rdy(0) && n < 5000) begin @(negedge clk); n++; end
    nchk++;
    if (h != 3 || sq0.size() != 3) begin
      $display("FAIL b2b_count got %0d handshakes %0d strobes want 3 and 3", h, sq0.size()); nerr++;
    end
    for (int k = 0; k < 3; k++) begin
      get_strobe(0, s, got);
      nchk++;
      if (!got || {s.rs, s.data} !== pres[k]) begin
        $display("FAIL b2b_strobe[%0d] got %h want %h", k, {s.rs, s.data}, pres[k]); nerr++;
      end
    end
    for (int k = 1; k < 3; k++) begin
      nchk++;
      if (th[k] - th[k-1] < 2 * EXEC + 5 || th[k] - th[k-1] > 2 * EXEC + 8) begin
        $display("FAIL b2b_period[%0d] got %0d cycles want %0d..%0d", k, th[k] - th[k-1], 2 * EXEC + 5, 2 * EXEC + 8); nerr++;
      end
    end
    sq0.delete();
  endtask

  task automatic test_random();
    logic rs;
    logic [7:0] d;
    int lowc, w, lo, hi;
    bit ok, got;
    strobe_t s;
    for (int k = 0; k < 10; k++) begin
      int sel;
      sel = k % 2;
      rs = 1'($urandom);
      d = rnd_byte(rs);
      send(sel, rs, d, lowc, ok);
      w = 2 * exp_wait_us(rs, d);
      lo = (sel == 0) ? w + 4 : w + 9;
      hi = (sel == 0) ? w + 8 : w + 14;
      nchk++;
      if (!ok || lowc < lo || lowc > hi) begin
        $display("FAIL rand_wait[%0d] dut%0d got low=%0d cycles want %0d..%0d", k, sel, lowc, lo, hi); nerr++;
      end
      if (sel == 0) begin
        get_strobe(0, s, got);
        nchk++;
        if (!got || s.rs !== rs || s.data !== d || sq0.size() != 0) begin
          $display("FAIL rand_strobe8[%0d] got rs=%b data=%h want rs=%b data=%h", k, s.rs, s.data, rs, d); nerr++;
        end
      end else begin
        get_strobe(1, s, got);
        nchk++;
        if (!got || s.rs !== rs || s.data !== {d[7:4], 4'h0}) begin
          $display("FAIL rand_hi4[%0d] got rs=%b data=%h want rs=%b data=%h", k, s.rs, s.data, rs, {d[7:4], 4'h0}); nerr++;
        end
        get_strobe(1, s, got);
        nchk++;
        if (!got || s.rs !== rs || s.data !== {d[3:0], 4'h0} || sq1.size() != 0) begin
          $display("FAIL rand_lo4[%0d] got rs=%b data=%h want rs=%b data=%h", k, s.rs, s.data, rs, {d[3:0], 4'h0}); nerr++;
        end
      end
    end
    nchk++;
    if (rw_bad || lo_nz) begin $display("FAIL rw_lownib got rw_bad=%0d lo_nz=%0d want 0 0", rw_bad, lo_nz); nerr++; end
  endtask

  task automatic test_reset_mid();
    int n, t0;
    bit got;
    strobe_t s;
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 8'h55);
    n = 0;
    while (!len[0] && n < 500) begin @(negedge clk); n++; end
    drive(0, 1'b0, 1'b0, 8'h00);
    nchk++;
    if (!len[0]) begin $display("FAIL rstmid_en timeout waiting for EN"); nerr++; end
    #100 rst_n = 0;
    #1;
    nchk++;
    if ({lrs[0], lrw[0], len[0], dat[0], rdy(0), done[0]} !== 13'd0) begin
      $display("FAIL rstmid_async got rs=%b en=%b data=%h rdy=%b done=%b want all 0", lrs[0], len[0], dat[0], rdy(0), done[0]);
      nerr++;
    end
    repeat (3) @(negedge clk);
    sq0.delete(); sq1.delete();
    rst_n = 1; t0 = cyc;
    n = 0;
    while (sq0.size() == 0 && n < 400) begin @(negedge clk); n++; end
    get_strobe(0, s, got);
    nchk++;
    if (!got || s.rs !== 1'b0 || s.data !== 8'h30 || s.t_rise - t0 < UDIV * (PWR - 1) || done[0] !== 1'b0) begin
      $display("FAIL rstmid_restart got got=%0d rs=%b data=%h delay=%0d done=%b want rs=0 data=30 delay>=%0d done=0",
               got, s.rs, s.data, s.t_rise - t0, done[0], UDIV * (PWR - 1));
      nerr++;
    end
  endtask

  initial begin
    test_reset();
    test_init8();
    test_init4();
    test_char41();
    test_clear_home();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end
endmodule

// File: doc/lcd_hd44780_ctrl.md
Name: lcd_hd44780_ctrl

Overview:
- Parametrised HD44780-compatible character-LCD controller; successor to the fixed 8-bit, fixed-clock LCD1602 driver.
- Runs the datasheet power-up and initialisation sequence with timed waits, in either 8-bit or 4-bit bus mode.
- Accepts command and data bytes from upstream logic over a valid/ready handshake, and generates correctly timed RS/EN/DATA strobes.
- No busy-flag reads: execution time is enforced by counters, so LCD_RW is tied to 0.

Parameters:
- CLK_HZ, 20000000: input clock frequency. Derived US_DIV = CLK_HZ/1000000, must be >= 1.
- BUS_4BIT, 0: 0 = 8-bit bus; 1 = 4-bit bus on LCD_DATA[7:4].
- ROWS, 2: display lines, 1 or 2. Sets the N bit of function set.
- POWERUP_US, 40000: wait after reset before the first init write.
- EXEC_US, 40: execution wait after a normal command or data write.
- CLEAR_US, 1640: execution wait after clear (0x01) or home (0x02/0x03).

Ports:
- lcd_clk_in, input, 1: the single system clock.
- lcd_rst_n_in, input, 1: reset.
- cmd_valid_in, input, 1: upstream has a byte to send.
- cmd_rs_in, input, 1: 0 = command, 1 = character data.
- cmd_data_in, input, 8: byte to write.
- cmd_ready_out, output, 1: controller can accept a byte this cycle.
- init_done_out, output, 1: init sequence complete; stays high until reset.
- LCD_RS, output, 1: register select.
- LCD_RW, output, 1: constant 0 (write only).
- LCD_EN, output, 1: enable strobe.
- LCD_DATA, output, 8: data bus. In 4-bit mode [3:0] is driven 0.

Interface decisions:
- One clock; reset is asynchronous and active-low.
- Clock port is lcd_clk_in; reset port is lcd_rst_n_in.

Behaviour:
- Reset values: LCD_RS=0, LCD_RW=0, LCD_EN=0, LCD_DATA=0, cmd_ready_out=0, init_done_out=0. The FSM enters PWRUP.
- Asserting reset at any point, including mid-strobe, aborts immediately to these values. Release restarts the full init sequence.
- Microsecond tick: a prescaler counts 0..US_DIV-1 and pulses tick once per microsecond. All waits count ticks. A wait of N us ends N ticks after entry, with +0/-1 us jitter allowed.
- States:
  - PWRUP: wait POWERUP_US, then INIT.
  - INIT: issue the next init entry through the write engine.
  - IDLE: cmd_ready_out=1.
  - SETUP: 1 us.
  - EN_HI: 1 us.
  - HOLD: 1 us.
  - WAIT: execution wait.
- Write engine, per bus transfer:
  - SETUP drives RS and DATA with EN=0.
  - EN_HI raises EN.
  - HOLD drops EN while keeping RS and DATA stable.
- In 4-bit mode a full byte is two transfers: high nibble, then low nibble, with no execution wait between them. WAIT follows only the second nibble.
- Init sequence, 8-bit mode:
  - 0x30, wait 4100 us.
  - 0x30, wait 100 us.
  - 0x30, wait EXEC_US.
  - FS, 0x08, 0x01 (wait CLEAR_US), 0x06, 0x0C; each of the others waits EXEC_US.
- Init sequence, 4-bit mode:
  - Single-nibble transfers 0x3 (wait 4100 us), 0x3 (wait 100 us), 0x3, 0x2, each with the indicated wait or EXEC_US.
  - Then FS, 0x08, 0x01, 0x06, 0x0C as full bytes.
- FS = {3'b001, ~BUS_4BIT, ROWS>1, 3'b000}. This gives 0x38 for 8-bit two-line and 0x28 for 4-bit two-line.
- Init writes always use RS=0.
- After the last init wait, init_done_out rises and the FSM enters IDLE.
- Handshake:
  - cmd_ready_out is high only in IDLE.
  - A transfer occurs on a clock edge where cmd_valid_in and cmd_ready_out are both high. cmd_rs_in and cmd_data_in are latched on that edge, and cmd_ready_out falls in the following cycle.
  - Upstream may change its inputs freely after the transfer.
  - cmd_valid_in asserted while ready=0 is ignored; it is not queued.
  - Ready returns in the cycle after WAIT completes.
- Execution wait: CLEAR_US if cmd_rs_in=0 and cmd_data_in[7:2]=0 and cmd_data_in!=0, otherwise EXEC_US. A command byte of 0x00 uses EXEC_US.
- Back-to-back: upstream holding valid high gets one transfer per write period. There are no bubbles beyond the defined wait.
- LCD_DATA holds its last value in IDLE. LCD_EN is never high outside EN_HI.

Test Plan:
- CLK_HZ=2000000, POWERUP_US=50, 8-bit: release reset, then:
  - Bus sequence is 0x30, 0x30, 0x30, 0x38, 0x08, 0x01, 0x06, 0x0C, all with RS=0.
  - EN-high width is 2 cycles per strobe.
  - Gap after the first 0x30 is at least 4100 us.
  - init_done_out rises after the last wait.
- Same setup, BUS_4BIT=1, ROWS=1: DATA[7:4] sequence is 3, 3, 3, 2, 2, 0, 0, 8, 0, 1, 0, 6, 0, C (FS=0x20). DATA[3:0] stays 0 throughout.
- After init, send rs=1, data 0x41: one strobe with RS=1 and DATA=0x41. DATA is stable from 1 us before EN rises to 1 us after EN falls. cmd_ready_out returns about 43 us later.
- Send rs=0, data 0x01: ready stays low for at least 1640 us. Then send 0x80 and confirm the EXEC_US wait applies.
- Hold valid high while streaming 3 bytes: exactly 3 strobes, one per handshake. Bytes presented while ready=0 are not written.
- Assert lcd_rst_n_in during EN_HI: LCD_EN drops asynchronously and all outputs return to reset values. After release the init sequence restarts from PWRUP.
